irq_arbiter: RTL and testbench
==============================

// Module: irq_arbiter
// PURPOSE
//  Interrupt scheduler between the peripheral irq lines (tim, uart_tx, uart_rx, fft) and the core.
//  Edge-latches source requests into pending bits and masks them with a software enable register.
//  Picks one winner (fixed priority or round-robin) and presents it to the core as irq_o/irq_id_o.
//  Tracks the request/ack/end-of-interrupt handshake. Register-mapped on the core data bus.
// PARAMETERS
//  NUM_SRC    4              number of interrupt sources, 2..16
//  ID_W       2              width of irq_id_o, clog2(NUM_SRC)
//  BASE_ADDR  32'h4000_0100  byte address of register block (4 words)
// PORTS
//  clk          in   1        system clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  src_irq_i    in   NUM_SRC  source irq lines, bit0=tim,1=uart_tx,2=uart_rx,3=fft
//  reg_we_i     in   1        register write strobe, one cycle
//  reg_addr_i   in   32       register byte address
//  reg_wdata_i  in   32       register write data
//  reg_rdata_o  out  32       register read data, combinational from reg_addr_i
//  irq_o        out  1        interrupt request to core
//  irq_id_o     out  ID_W     id of requested / in-service source
//  irq_ack_i    in   1        core accepts request, one cycle
//  irq_eoi_i    in   1        core finished handler (mret), one cycle
// BEHAVIOUR
//  Reset (async, rst_n=0): enable=0, pending=0, mode=0, rr_ptr=0, src_q=0, state=IDLE, irq_o=0, irq_id_o=0.
//  Registers (offset from BASE_ADDR; writes only when reg_we_i):
//   0x0 ENABLE  RW  [NUM_SRC-1:0] per-source enable. Upper bits read 0.
//   0x4 PENDING R/W1C  [NUM_SRC-1:0] latched requests. Writing 1 clears the bit.
//   0x8 MODE    RW  bit0: 0=fixed priority (bit0 highest), 1=round-robin.
//   0xC STATUS  RO  [ID_W-1:0]=irq_id_o, [8]=REQ state, [9]=SERVICE state.
//   Unmapped addresses read 0. Writes to them are ignored.
//  Pending: src_q registers src_irq_i. A rising edge (src & ~src_q) sets pending[i] at the next clk.
//   Source at 1 out of reset: src_q=0, so it counts as an edge.
//   Set beats a W1C clear or an ack clear of the same bit in the same cycle.
//  Winner: cand = pending & enable.
//   Fixed mode: lowest set index wins.
//   Round-robin mode: first set index searching upward from rr_ptr, wrapping NUM_SRC-1 -> 0.
//  FSM:
//   IDLE:    if cand!=0: latch irq_id_o=winner, go REQ. irq_o is registered.
//            Latency: src edge sampled at clk t -> pending at t -> irq_o=1 after clk t+1.
//   REQ:     irq_o=1, irq_id_o held stable even if higher priority arrives.
//            On irq_ack_i: clear pending[id], rr_ptr=(id+1) mod NUM_SRC, irq_o=0, go SERVICE.
//            Else if pending[id]&enable[id] becomes 0 (software clear/disable): irq_o=0, go IDLE (withdraw).
//            Ack and withdraw condition in the same cycle: ack wins.
//   SERVICE: irq_o=0, irq_id_o holds in-service id. No nesting.
//            Edges keep latching into pending, including same source.
//            On irq_eoi_i: go IDLE. Next request can assert 1 cycle later (IDLE evaluates, then REQ).
//  irq_ack_i outside REQ and irq_eoi_i outside SERVICE are ignored.
//  Reset mid-operation: immediate return to reset values. An in-flight request is dropped, not replayed.
//  MODE change takes effect at the next IDLE arbitration. It never alters a latched irq_id_o.
// TESTING
//  1 Reset, ENABLE=0xF, pulse src[2] 1 cycle -> PENDING=0x4. irq_o=1, irq_id_o=2 two clks after edge.
//    ack -> PENDING=0, irq_o=0, STATUS[9]=1. eoi -> STATUS=0.
//  2 Fixed mode, edges on src[3] and src[1] same cycle -> id 1 served first.
//    After eoi -> id 3 requested. PENDING sequence 0xA -> 0x8 -> 0x0.
//  3 MODE=1, src[0..3] all pending, serve each with ack/eoi -> ids 0,1,2,3.
//    Re-pend all -> order restarts at rr_ptr=0 after id 3 wrap.
//  4 In REQ for id 1, write PENDING=0x2 (W1C) without ack -> irq_o drops next clk, state IDLE.
//    Same with ack in that cycle -> SERVICE.
//  5 Pending edge on src[0] while ENABLE=0 -> PENDING=0x1, irq_o stays 0.
//    Write ENABLE=0x1 -> irq_o=1, id 0 one clk later.
//  6 Assert rst_n=0 asynchronously mid-SERVICE -> irq_o, PENDING, ENABLE, STATUS read 0 before next clk edge.

Source files
------------

// File: rtl/irq_arbiter.sv
// irq_arbiter: edge-latched, maskable interrupt scheduler for the core.
// Register-mapped ENABLE/PENDING/MODE/STATUS with a req/ack/eoi handshake.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   src_irq_i    source irq lines (0=tim, 1=uart_tx, 2=uart_rx, 3=fft)
//   reg_we_i     register write strobe, one cycle
//   reg_addr_i   register byte address
//   reg_wdata_i  register write data
//   reg_rdata_o  register read data, combinational from reg_addr_i
//   irq_o        registered interrupt request to the core
//   irq_id_o     id of the requested / in-service source (0 when idle)
//   irq_ack_i    core accepts the request, one cycle
//   irq_eoi_i    core finished the handler, one cycle
module irq_arbiter #(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned ID_W      = 2,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_irq_i,
    input  logic               reg_we_i,
    input  logic [31:0]        reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic [31:0]        reg_rdata_o,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o,
    input  logic               irq_ack_i,
    input  logic               irq_eoi_i
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q;
    logic               mode_q;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    id_q, id_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] clr;
    logic [ID_W-1:0]    win_fix;
    logic [ID_W-1:0]    win_rr;
    logic [ID_W-1:0]    winner;
    logic               rr_found;
    int                 rr_idx;

    logic sel_en;
    logic sel_pend;
    logic sel_mode;
    logic sel_stat;

    // Only the low bits of the write data are architected.
    logic unused_wdata;
    assign unused_wdata = ^reg_wdata_i;

    assign sel_en   = (reg_addr_i == BASE_ADDR);
    assign sel_pend = (reg_addr_i == BASE_ADDR + 32'h4);
    assign sel_mode = (reg_addr_i == BASE_ADDR + 32'h8);
    assign sel_stat = (reg_addr_i == BASE_ADDR + 32'hC);

    // A source held high across reset counts as an edge because src_q
    // comes out of reset at zero.
    assign rise = src_irq_i & ~src_q;
    assign cand = pending_q & enable_q;

    // Fixed priority: lowest index wins, so scan downward and let the
    // last hit overwrite.
    always_comb begin
        win_fix = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_fix = ID_W'(i);
            end
        end
    end

    // Round-robin: first candidate at or above rr_q, wrapping to 0.
    always_comb begin
        win_rr   = '0;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            rr_idx = int'(rr_q) + k;
            if (rr_idx >= int'(NUM_SRC)) begin
                rr_idx = rr_idx - int'(NUM_SRC);
            end
            if (!rr_found && cand[rr_idx]) begin
                rr_found = 1'b1;
                win_rr   = ID_W'(rr_idx);
            end
        end
    end

    assign winner = mode_q ? win_rr : win_fix;

    // Next state. Clears are collected in clr and applied before the
    // rising-edge set, so a new edge always survives a same-cycle clear.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        rr_d    = rr_q;
        clr     = '0;
        if (reg_we_i && sel_pend) begin
            clr = reg_wdata_i[NUM_SRC-1:0];
        end
        unique case (state_q)
            ST_IDLE: begin
                if (|cand) begin
                    state_d = ST_REQ;
                    id_d    = winner;
                end
            end
            ST_REQ: begin
                if (irq_ack_i) begin
                    clr[id_q] = 1'b1;
                    if (id_q == ID_W'(NUM_SRC - 1)) begin
                        rr_d = '0;
                    end else begin
                        rr_d = id_q + 1'b1;
                    end
                    state_d = ST_SERVICE;
                end else if (!(pending_q[id_q] && enable_q[id_q])) begin
                    // Software cleared or masked the request: withdraw.
                    state_d = ST_IDLE;
                    id_d    = '0;
                end
            end
            ST_SERVICE: begin
                if (irq_eoi_i) begin
                    state_d = ST_IDLE;
                    id_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                id_d    = '0;
            end
        endcase
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= 1'b0;
            rr_q      <= '0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_irq_i;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            id_q      <= id_d;
            if (reg_we_i && sel_en) begin
                enable_q <= reg_wdata_i[NUM_SRC-1:0];
            end
            if (reg_we_i && sel_mode) begin
                mode_q <= reg_wdata_i[0];
            end
        end
    end

    assign irq_o    = (state_q == ST_REQ);
    assign irq_id_o = id_q;

    always_comb begin
        reg_rdata_o = '0;
        unique case (1'b1)
            sel_en: begin
                reg_rdata_o[NUM_SRC-1:0] = enable_q;
            end
            sel_pend: begin
                reg_rdata_o[NUM_SRC-1:0] = pending_q;
            end
            sel_mode: begin
                reg_rdata_o[0] = mode_q;
            end
            sel_stat: begin
                reg_rdata_o[ID_W-1:0] = id_q;
                reg_rdata_o[8]        = (state_q == ST_REQ);
                reg_rdata_o[9]        = (state_q == ST_SERVICE);
            end
            default: begin
                reg_rdata_o = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: scoreboard bench for irq_arbiter.
// Directed scenarios plus randomized batches checked against a queue model.
module tb_irq_arbiter;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h4000_0100;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  src   = '0;
    logic        we    = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    logic [1:0]  id;
    logic        ack   = 1'b0;
    logic        eoi   = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int rr_m  = 0;

    irq_arbiter #(
        .NUM_SRC  (4),
        .ID_W     (2),
        .BASE_ADDR(BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_irq_i  (src),
        .reg_we_i   (we),
        .reg_addr_i (addr),
        .reg_wdata_i(wdata),
        .reg_rdata_o(rdata),
        .irq_o      (irq),
        .irq_id_o   (id),
        .irq_ack_i  (ack),
        .irq_eoi_i  (eoi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        addr  = BASE + off;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] off,
                          input logic [31:0] exp);
        addr = BASE + off;
        #1;
        chk(nm, rdata, exp);
        addr = '0;
    endtask

    task automatic pulse_src(input logic [3:0] m);
        src = m;
        tick();
        src = '0;
    endtask

    task automatic wait_irq();
        int c = 0;
        while (!irq && c < 20) begin
            tick();
            c++;
        end
        chk("irq_seen", {31'd0, irq}, 32'd1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    task automatic serve();
        wait_irq();
        do_ack();
        do_eoi();
    endtask

    // Reference model: a batch of requests that are all pending before
    // arbitration starts is served in ascending index order, starting at
    // 0 (fixed) or at the round-robin pointer (round-robin). Every ack
    // moves the pointer past the served id.
    task automatic expect_order(input logic [3:0] cand, input bit rr_mode);
        int start;
        int last;
        logic [3:0] c;
        c     = cand;
        start = rr_mode ? rr_m : 0;
        last  = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (c[idx]) begin
                exp_q.push_back(idx);
                last = idx;
            end
        end
        if (last >= 0) begin
            rr_m = (last + 1) % N;
        end
    endtask

    // Monitor: on every new request compare the presented id with the
    // scoreboard, and check the id stays stable while requesting.
    initial begin
        logic       irq_prev;
        logic [1:0] id_held;
        irq_prev = 1'b0;
        id_held  = '0;
        forever begin
            @(negedge clk);
            if (irq && !irq_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected: got id %0d want none", id);
                end else begin
                    chk("sb_id", {30'd0, id}, exp_q.pop_front());
                end
                id_held = id;
            end else if (irq && irq_prev) begin
                if (id !== id_held) begin
                    chk("id_stable", {30'd0, id}, {30'd0, id_held});
                end
            end
            irq_prev = irq;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] p;
        logic [3:0] e;
        logic [3:0] c;
        bit         m;
        int         cnt;

        #1;
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_id", {30'd0, id}, 32'd0);
        rd_chk("rst_status", 32'hC, 32'd0);
        rd_chk("rst_pend", 32'h4, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Unmapped write ignored, unmapped read 0.
        wr(32'h10, 32'hF);
        rd_chk("unmapped_rd", 32'h10, 32'd0);
        rd_chk("unmapped_en", 32'h0, 32'd0);

        // 1: single source, latency, ack/eoi.
        wr(32'h0, 32'hF);
        rd_chk("en_rd", 32'h0, 32'hF);
        expect_order(4'h4, 1'b0);
        pulse_src(4'h4);
        rd_chk("t1_pend", 32'h4, 32'h4);
        chk("t1_irq_lat", {31'd0, irq}, 32'd0);
        tick();
        chk("t1_irq", {31'd0, irq}, 32'd1);
        chk("t1_id", {30'd0, id}, 32'd2);
        rd_chk("t1_stat_req", 32'hC, 32'h102);
        do_ack();
        rd_chk("t1_pend_ack", 32'h4, 32'h0);
        chk("t1_irq_ack", {31'd0, irq}, 32'd0);
        rd_chk("t1_stat_svc", 32'hC, 32'h202);
        do_eoi();
        rd_chk("t1_stat_eoi", 32'hC, 32'h0);

        // 2: fixed priority, simultaneous edges.
        expect_order(4'hA, 1'b0);
        pulse_src(4'hA);
        rd_chk("t2_pend_a", 32'h4, 32'hA);
        wait_irq();
        do_ack();
        rd_chk("t2_pend_8", 32'h4, 32'h8);
        do_eoi();
        chk("t2_idle_gap", {31'd0, irq}, 32'd0);
        wait_irq();
        do_ack();
        rd_chk("t2_pend_0", 32'h4, 32'h0);
        do_eoi();

        // 3: round-robin, two full rounds.
        wr(32'h8, 32'h1);
        rd_chk("mode_rd", 32'h8, 32'h1);
        for (int r = 0; r < 2; r++) begin
            expect_order(4'hF, 1'b1);
            pulse_src(4'hF);
            for (int k = 0; k < 4; k++) begin
                serve();
            end
        end
        rd_chk("t3_pend", 32'h4, 32'h0);

        // 4: withdraw via W1C, then W1C together with ack.
        exp_q.push_back(1);
        pulse_src(4'h2);
        wait_irq();
        wr(32'h4, 32'h2);
        chk("t4_req_hold", {31'd0, irq}, 32'd1);
        tick();
        chk("t4_withdraw", {31'd0, irq}, 32'd0);
        rd_chk("t4_stat_idle", 32'hC, 32'h0);
        expect_order(4'h2, 1'b1);
        pulse_src(4'h2);
        wait_irq();
        addr  = BASE + 32'h4;
        wdata = 32'h2;
        we    = 1'b1;
        ack   = 1'b1;
        tick();
        we    = 1'b0;
        ack   = 1'b0;
        rd_chk("t4_stat_svc", 32'hC, 32'h201);
        rd_chk("t4_pend", 32'h4, 32'h0);
        do_eoi();

        // 5: masked pending, then enable.
        wr(32'h0, 32'h0);
        pulse_src(4'h1);
        tick();
        tick();
        rd_chk("t5_pend", 32'h4, 32'h1);
        chk("t5_masked", {31'd0, irq}, 32'd0);
        expect_order(4'h1, 1'b1);
        wr(32'h0, 32'h1);
        chk("t5_irq_early", {31'd0, irq}, 32'd0);
        tick();
        chk("t5_irq", {31'd0, irq}, 32'd1);
        chk("t5_id", {30'd0, id}, 32'd0);
        do_ack();
        do_eoi();
        wr(32'h0, 32'hF);

        // 6: async reset in SERVICE with another request pending.
        expect_order(4'h8, 1'b1);
        pulse_src(4'h8);
        wait_irq();
        do_ack();
        pulse_src(4'h1);
        rd_chk("t6_stat_svc", 32'hC, 32'h203);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_irq", {31'd0, irq}, 32'd0);
        rd_chk("t6_pend", 32'h4, 32'h0);
        rd_chk("t6_en", 32'h0, 32'h0);
        rd_chk("t6_stat", 32'hC, 32'h0);
        rr_m = 0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t6_no_replay", {31'd0, irq}, 32'd0);

        // Randomized batches.
        for (int it = 0; it < 40; it++) begin
            wr(32'h0, 32'h0);
            p = 4'($urandom_range(1, 15));
            pulse_src(p);
            m = 1'($urandom_range(0, 1));
            wr(32'h8, {31'd0, m});
            e = 4'($urandom_range(0, 15));
            c = p & e;
            expect_order(c, m);
            wr(32'h0, {28'd0, e});
            cnt = $countones(c);
            for (int k = 0; k < cnt; k++) begin
                serve();
            end
            tick();
            rd_chk("rnd_pend", 32'h4, {28'd0, p & ~e});
            chk("rnd_irq_idle", {31'd0, irq}, 32'd0);
            wr(32'h4, 32'hF);
            rd_chk("rnd_pend_clr", 32'h4, 32'h0);
        end

        tick();
        tick();
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
